// File: rtl/dvr_pack.sv
// dvr_pack: types and helpers shared by dvr_if based datapath blocks.
package dvr_pack;
    typedef enum logic {DSZ_IDLE, DSZ_SEND} dsz_state_e;

    // Map the beat counter to the slice it selects, honouring emission order.
    function automatic int unsigned slice_idx(input int unsigned beat_cnt, input int unsigned ratio, input bit lsb_first);
        return lsb_first ? beat_cnt : ratio - 1 - beat_cnt;
    endfunction
endpackage

// File: rtl/generic_func_pack.sv
// generic_func_pack: shared elaboration-time helper functions.
package generic_func_pack;
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction
endpackage

// File: rtl/dvr_if.sv
// dvr_if: data/valid/ready handshake; master consumes (drives rdy), slave produces.
interface dvr_if #(parameter int W = 8);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    modport master (input data, input vld, output rdy);
    modport slave  (output data, output vld, input rdy);
endinterface

// File: rtl/dvr_downsizer.sv
// dvr_downsizer: pops one wide word and emits it as RATIO narrow beats, no bubble between words.
module dvr_downsizer
    import generic_func_pack::*;
    import dvr_pack::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH / RATIO,
    parameter bit LSB_FIRST = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    dvr_if.master  in_word,
    dvr_if.slave   out_beat,
    output logic   out_last,
    output logic   busy
);
    localparam int CW = $clog2(RATIO);

    if (!is_pow2(RATIO) || RATIO < 2) begin : g_ratio_chk
        $error("dvr_downsizer: RATIO must be a power of 2 and >= 2");
    end
    if (IN_WIDTH != RATIO * OUT_WIDTH) begin : g_width_chk
        $error("dvr_downsizer: IN_WIDTH must equal RATIO*OUT_WIDTH");
    end

    dsz_state_e          state, next_state;
    logic [CW-1:0]       beat_cnt, idx;
    logic [IN_WIDTH-1:0] word_q;
    logic                send, in_acc, out_acc;

    assign send         = state == DSZ_SEND;
    assign idx          = CW'(slice_idx(32'(beat_cnt), RATIO, LSB_FIRST));
    assign out_last     = send && beat_cnt == CW'(RATIO - 1);
    assign busy         = send;
    assign out_beat.vld = send;
    assign out_beat.data = send ? word_q[idx*OUT_WIDTH +: OUT_WIDTH] : '0;
    // A new word may land in the same cycle the last beat leaves, keeping the output stream gapless.
    assign in_word.rdy  = !send || (out_beat.rdy && out_last);
    assign in_acc       = in_word.vld && in_word.rdy;
    assign out_acc      = send && out_beat.rdy;

    always_comb begin
        next_state = state;
        if (in_acc)
            next_state = DSZ_SEND;
        else if (out_acc && out_last)
            next_state = DSZ_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DSZ_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= next_state;
            if (in_acc)
                beat_cnt <= '0;
            else if (out_acc && !out_last)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_q <= '0;
        else if (in_acc)
            word_q <= in_word.data;
    end
endmodule

// File: tb/tb_dvr_downsizer.sv
// tb_dvr_downsizer: directed and random checks of both slice orders against a beat-counting model.
module tb_dvr_downsizer;
    localparam int R = 4;

    logic        clk = 0, rst_n = 0;
    logic [31:0] in_data = 0;
    logic        in_vld = 0, out_rdy = 0;
    logic        last_l, busy_l, last_m, busy_m;
    int          tests = 0, fails = 0;

    dvr_if #(.W(32)) in_l();
    dvr_if #(.W(32)) in_m();
    dvr_if #(.W(8))  out_l();
    dvr_if #(.W(8))  out_m();

    assign in_l.data = in_data;
    assign in_l.vld  = in_vld;
    assign in_m.data = in_data;
    assign in_m.vld  = in_vld;
    assign out_l.rdy = out_rdy;
    assign out_m.rdy = out_rdy;

    dvr_downsizer #(.IN_WIDTH(32), .RATIO(R), .OUT_WIDTH(8), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_word(in_l), .out_beat(out_l), .out_last(last_l), .busy(busy_l));
    dvr_downsizer #(.IN_WIDTH(32), .RATIO(R), .OUT_WIDTH(8), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_word(in_m), .out_beat(out_m), .out_last(last_m), .busy(busy_m));

    always #5 clk = ~clk;

    // Model: the word held and how many of its beats are still owed.
    logic [31:0] cur = 0;
    int          rem = 0, words = 0, beats = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rem = 0;
        else begin
            automatic bit acc_i = in_vld && (rem == 0 || (out_rdy && rem == 1));
            if (rem > 0 && out_rdy) rem--;
            if (acc_i) begin
                cur = in_data;
                rem = R;
                words++;
            end
        end
    end

    always @(posedge clk) if (rst_n && out_l.vld && out_rdy) beats++;

    task automatic cmp_dut(input string nm, input logic v, input logic [7:0] d, input logic l,
                           input logic b, input logic r, input bit lsb);
        automatic bit   ev = rem > 0;
        automatic bit   el = rem == 1;
        automatic bit   er = rem == 0 || (out_rdy && rem == 1);
        automatic int   ix = lsb ? R - rem : rem - 1;
        automatic logic [7:0] ed = 8'(cur >> (8 * ix));
        tests++;
        if (v !== ev || l !== el || b !== ev || r !== er || (ev && d !== ed)) begin
            fails++;
            if (fails < 30)
                $display("FAIL model_%s t=%0t: vld/last/busy/rdy/data got %b%b%b%b %h, want %b%b%b%b %h",
                         nm, $time, v, l, b, r, d, ev, el, ev, er, ed);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        cmp_dut("lsb", out_l.vld, out_l.data, last_l, busy_l, in_l.rdy, 1);
        cmp_dut("msb", out_m.vld, out_m.data, last_m, busy_m, in_m.rdy, 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string nm, input logic [7:0] dl, input logic [7:0] dm, input logic l);
        chk({nm, "_vld"}, {31'b0, out_l.vld}, 1);
        chk({nm, "_data_lsb"}, {24'b0, out_l.data}, {24'b0, dl});
        chk({nm, "_data_msb"}, {24'b0, out_m.data}, {24'b0, dm});
        chk({nm, "_last"}, {31'b0, last_l}, {31'b0, l});
    endtask

    initial begin
        int w0, b0;
        logic acc;
        repeat (3) step();
        chk("reset_vld", {31'b0, out_l.vld}, 0);
        chk("reset_data", {24'b0, out_l.data}, 0);
        chk("reset_rdy_low", {31'b0, in_l.rdy}, 1);
        rst_n = 1;
        step();
        chk("reset_rdy", {31'b0, in_l.rdy}, 1);
        chk("reset_busy", {31'b0, busy_l}, 0);

        // Single word, both orders
        out_rdy = 1; in_data = 32'hDDCCBBAA; in_vld = 1;
        step(); in_vld = 0;
        beat("w1b0", 8'hAA, 8'hDD, 0); step();
        beat("w1b1", 8'hBB, 8'hCC, 0); step();
        beat("w1b2", 8'hCC, 8'hBB, 0); step();
        beat("w1b3", 8'hDD, 8'hAA, 1); step();
        chk("w1_idle", {31'b0, out_l.vld}, 0);

        // Back-to-back words with no bubble
        in_data = 32'h44332211; in_vld = 1;
        step(); in_data = 32'h88776655;
        beat("bb0", 8'h11, 8'h44, 0); step();
        beat("bb1", 8'h22, 8'h33, 0); step();
        beat("bb2", 8'h33, 8'h22, 0); step();
        beat("bb3", 8'h44, 8'h11, 1);
        chk("bb3_in_rdy", {31'b0, in_l.rdy}, 1);
        step(); in_vld = 0;
        beat("bb4", 8'h55, 8'h88, 0); step();
        beat("bb5", 8'h66, 8'h77, 0); step();
        beat("bb6", 8'h77, 8'h66, 0); step();
        beat("bb7", 8'h88, 8'h55, 1); step();
        chk("bb_idle", {31'b0, busy_l}, 0);

        // Backpressure holds the current beat
        in_data = 32'hDDCCBBAA; in_vld = 1;
        step(); in_vld = 0;
        step(); out_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            beat("hold", 8'hBB, 8'hCC, 0);
            chk("hold_in_rdy", {31'b0, in_l.rdy}, 0);
        end
        out_rdy = 1;
        step(); beat("res2", 8'hCC, 8'hBB, 0);
        step(); beat("res3", 8'hDD, 8'hAA, 1);
        step();

        // Async reset mid-word discards it
        in_vld = 1;
        step(); in_vld = 0;
        step(); step();
        chk("pre_rst_data", {24'b0, out_l.data}, 32'hCC);
        rst_n = 0; #1;
        chk("rst_vld", {31'b0, out_l.vld}, 0);
        chk("rst_last", {31'b0, last_l}, 0);
        chk("rst_busy", {31'b0, busy_l}, 0);
        chk("rst_data", {24'b0, out_l.data}, 0);
        #1 rst_n = 1;
        step();
        in_data = 32'h0A0B0C0D; in_vld = 1;
        step(); in_vld = 0;
        beat("ar0", 8'h0D, 8'h0A, 0); step();
        beat("ar1", 8'h0C, 8'h0B, 0); step();
        beat("ar2", 8'h0B, 8'h0C, 0); step();
        beat("ar3", 8'h0A, 8'h0D, 1); step();

        // Random traffic; the source holds a word until it is accepted
        w0 = words; b0 = beats;
        in_data = $urandom; in_vld = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = in_vld && in_l.rdy;
            @(posedge clk); #1;
            if (acc || !in_vld) begin
                in_data = $urandom;
                in_vld = $urandom_range(0, 3) != 0;
            end
            out_rdy = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        acc = in_vld && in_l.rdy;
        @(posedge clk); #1;
        in_vld = 0; out_rdy = 1;
        repeat (2 * R + 2) step();
        chk("drain_busy", {31'b0, busy_l}, 0);
        chk("beat_count", 32'(beats - b0), 32'(R * (words - w0)));
        tests++;
        if (words - w0 < 100) begin
            fails++;
            $display("FAIL rand_words: got %0d, want at least 100", words - w0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
